projectile_flight: RTL and testbench

PROJECTILE_FLIGHT -- requirements
Module: projectile_flight

---
 rtl/projectile_flight.sv | 129 ++++++++++++
 tb/tb_projectile_flight.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_flight.sv
// Projectile flight engine: launches from the thrower's side, steps a ballistic
// trajectory once per frame and reports hit/miss with a one-cycle end_throw pulse.
module projectile_flight #(
  parameter int FRAME_DIV  = 1000000,
  parameter int P1_X       = 100,
  parameter int P2_X       = 900,
  parameter int START_Y    = 600,
  parameter int GROUND_Y   = 600,
  parameter int TARGET_TOP = 560,
  parameter int TARGET_HW  = 24,
  parameter int GRAVITY    = 1,
  parameter int MAX_FRAMES = 255
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        throw_flag,
  input  logic [3:0]  power,
  input  logic        turn,
  output logic        end_throw,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        visible,
  output logic [1:0]  result
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int FW = (MAX_FRAMES > 0) ? $clog2(MAX_FRAMES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, FLY, DONE} state_t;

  state_t             state;
  logic               dir;
  logic               checking;
  logic signed [11:0] x;
  logic signed [11:0] y;
  logic signed [11:0] vy;
  logic [4:0]         vx;
  logic [CW-1:0]      clk_cnt;
  logic [FW-1:0]      frame_cnt;

  int   x_int;
  int   y_int;
  int   dx;
  logic frame_tick;
  logic hit;
  logic ground;
  logic oob;
  logic timeout;

  // Termination tests use sign-extended positions so x < 0 is detectable.
  always_comb begin
    x_int      = int'(x);
    y_int      = int'(y);
    dx         = x_int - (dir ? P1_X : P2_X);
    hit        = (dx <= TARGET_HW) && (dx >= -TARGET_HW) && (y_int >= TARGET_TOP);
    ground     = (y_int >= GROUND_Y);
    oob        = (x_int < 0) || (x_int > 1023);
    timeout    = (frame_cnt == FW'(MAX_FRAMES));
    frame_tick = (clk_cnt == CW'(FRAME_DIV - 1));
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      checking  <= 1'b0;
      x         <= '0;
      y         <= '0;
      vx        <= '0;
      vy        <= '0;
      clk_cnt   <= '0;
      frame_cnt <= '0;
      end_throw <= 1'b0;
      visible   <= 1'b0;
      result    <= 2'b00;
    end else begin
      end_throw <= 1'b0;
      unique case (state)
        IDLE: begin
          if (throw_flag) begin
            state   <= LAUNCH;
            visible <= 1'b1;
          end
        end
        LAUNCH: begin
          dir       <= turn;
          x         <= turn ? 12'(P2_X) : 12'(P1_X);
          y         <= 12'(START_Y);
          vx        <= {1'b0, power} + 5'd2;
          vy        <= 12'({8'b0, power}) + 12'd4;
          clk_cnt   <= '0;
          frame_cnt <= '0;
          checking  <= 1'b0;
          result    <= 2'b00;
          state     <= FLY;
        end
        FLY: begin
          // Termination is judged the cycle after a tick, on the freshly updated position.
          if (checking && (hit || ground || oob || timeout)) begin
            state     <= DONE;
            end_throw <= 1'b1;
            visible   <= 1'b0;
            checking  <= 1'b0;
            result    <= hit ? 2'b10 : 2'b01;
          end else begin
            checking <= frame_tick;
            if (frame_tick) begin
              clk_cnt   <= '0;
              x         <= dir ? (x - $signed({7'b0, vx})) : (x + $signed({7'b0, vx}));
              y         <= y - vy;
              vy        <= vy - 12'(GRAVITY);
              frame_cnt <= frame_cnt + 1'b1;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (!throw_flag) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x_pos = x[10:0];
  assign y_pos = y[10:0];

endmodule

// File: tb/tb_projectile_flight.sv
// Directed bench for projectile_flight: four instances with different
// parameter sets cover ground, hit, reverse-direction/bounds and timeout flights.
module tb_projectile_flight;

  logic        clk;
  logic        rst;
  logic        thr[4];
  logic [3:0]  pw[4];
  logic        tn[4];
  logic        et[4];
  logic [10:0] xp[4];
  logic [10:0] yp[4];
  logic        vis[4];
  logic [1:0]  res[4];

  int checks;
  int failures;

  logic [10:0] fx[64];
  logic [10:0] fy[64];
  int          nfr;
  int          npulse;
  logic        done_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  projectile_flight #(.FRAME_DIV(4), .P1_X(100), .P2_X(900)) dut_a (
    .clk60MHz(clk), .rst(rst), .throw_flag(thr[0]), .power(pw[0]), .turn(tn[0]),
    .end_throw(et[0]), .x_pos(xp[0]), .y_pos(yp[0]), .visible(vis[0]), .result(res[0])
  );

  projectile_flight #(.FRAME_DIV(4), .P1_X(100), .P2_X(116), .TARGET_HW(8),
                      .TARGET_TOP(595)) dut_h (
    .clk60MHz(clk), .rst(rst), .throw_flag(thr[1]), .power(pw[1]), .turn(tn[1]),
    .end_throw(et[1]), .x_pos(xp[1]), .y_pos(yp[1]), .visible(vis[1]), .result(res[1])
  );

  projectile_flight #(.FRAME_DIV(4), .P1_X(900), .P2_X(100)) dut_s (
    .clk60MHz(clk), .rst(rst), .throw_flag(thr[2]), .power(pw[2]), .turn(tn[2]),
    .end_throw(et[2]), .x_pos(xp[2]), .y_pos(yp[2]), .visible(vis[2]), .result(res[2])
  );

  projectile_flight #(.FRAME_DIV(4), .P1_X(100), .P2_X(900), .GROUND_Y(2000),
                      .MAX_FRAMES(5)) dut_t (
    .clk60MHz(clk), .rst(rst), .throw_flag(thr[3]), .power(pw[3]), .turn(tn[3]),
    .end_throw(et[3]), .x_pos(xp[3]), .y_pos(yp[3]), .visible(vis[3]), .result(res[3])
  );

  // Raises throw_flag and records each new position seen after the launch position appears.
  task automatic fly(input int d, input logic [10:0] launch_x);
    logic [10:0] px;
    logic        started;
    nfr     = 0;
    npulse  = 0;
    done_ok = 1'b0;
    started = 1'b0;
    px      = launch_x;
    thr[d]  = 1'b1;
    for (int c = 0; c < 300 && !done_ok; c++) begin
      @(posedge clk); #1;
      if (et[d]) begin
        npulse++;
        done_ok = 1'b1;
      end else if (vis[d]) begin
        if (!started && xp[d] == launch_x) started = 1'b1;
        else if (started && xp[d] != px) begin
          if (nfr < 64) begin
            fx[nfr] = xp[d];
            fy[nfr] = yp[d];
          end
          nfr++;
          px = xp[d];
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (et[d]) npulse++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      thr[d] = 1'b0;
      pw[d]  = 4'd0;
      tn[d]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({et[d], vis[d], res[d], xp[d], yp[d]} !== 26'd0) begin
        failures++;
        $display("FAIL reset dut%0d: et=%0b vis=%0b res=%0b x=%0d y=%0d required all 0",
                 d, et[d], vis[d], res[d], xp[d], yp[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ground();
    int ex[5];
    int ey[5];
    ex = '{102, 104, 106, 108, 110};
    ey = '{596, 593, 591, 590, 590};
    pw[0] = 4'd0;
    tn[0] = 1'b0;
    fly(0, 11'd100);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fx[i] !== 11'(ex[i]) || fy[i] !== 11'(ey[i])) begin
        failures++;
        $display("FAIL ground_frame%0d: got (%0d,%0d) required (%0d,%0d)",
                 i + 1, fx[i], fy[i], ex[i], ey[i]);
      end
    end
    checks++;
    if (nfr !== 9) begin
      failures++;
      $display("FAIL ground_frames: got %0d required 9", nfr);
    end
    checks++;
    if (xp[0] !== 11'd118 || yp[0] !== 11'd600) begin
      failures++;
      $display("FAIL ground_final: got (%0d,%0d) required (118,600)", xp[0], yp[0]);
    end
    checks++;
    if (res[0] !== 2'b01) begin
      failures++;
      $display("FAIL ground_result: got %b required 01", res[0]);
    end
    checks++;
    if (npulse !== 1) begin
      failures++;
      $display("FAIL ground_pulses: got %0d required 1", npulse);
    end
  endtask

  task automatic test_done_hold();
    logic bad;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (et[0] || vis[0] || res[0] !== 2'b01 || xp[0] !== 11'd118) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL done_hold: got relaunch/pulse=%0b required 0", bad);
    end
    thr[0] = 1'b0;
    @(posedge clk); #1;
    thr[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vis[0] !== 1'b1) begin
      failures++;
      $display("FAIL relaunch_visible: got %0b required 1", vis[0]);
    end
  endtask

  // throw_flag drops right after the relaunch; the flight must still complete.
  task automatic test_drop_midflight();
    logic seen;
    seen   = 1'b0;
    thr[0] = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      if (et[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL drop_end_throw: got %0b required 1", seen);
    end
    checks++;
    if (xp[0] !== 11'd118 || yp[0] !== 11'd600 || res[0] !== 2'b01) begin
      failures++;
      $display("FAIL drop_final: got (%0d,%0d) res=%b required (118,600) res=01",
               xp[0], yp[0], res[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hit();
    pw[1] = 4'd0;
    tn[1] = 1'b0;
    fly(1, 11'd100);
    checks++;
    if (nfr !== 8) begin
      failures++;
      $display("FAIL hit_frames: got %0d required 8", nfr);
    end
    checks++;
    if (xp[1] !== 11'd116 || yp[1] !== 11'd596) begin
      failures++;
      $display("FAIL hit_final: got (%0d,%0d) required (116,596)", xp[1], yp[1]);
    end
    checks++;
    if (res[1] !== 2'b10) begin
      failures++;
      $display("FAIL hit_result: got %b required 10", res[1]);
    end
    checks++;
    if (npulse !== 1) begin
      failures++;
      $display("FAIL hit_pulses: got %0d required 1", npulse);
    end
  endtask

  task automatic test_swap();
    pw[2] = 4'd15;
    tn[2] = 1'b1;
    fly(2, 11'd100);
    checks++;
    if (fx[0] !== 11'd83 || fy[0] !== 11'd581 || fx[1] !== 11'd66 || fy[1] !== 11'd563) begin
      failures++;
      $display("FAIL swap_frames12: got (%0d,%0d),(%0d,%0d) required (83,581),(66,563)",
               fx[0], fy[0], fx[1], fy[1]);
    end
    checks++;
    if (nfr !== 6) begin
      failures++;
      $display("FAIL swap_frames: got %0d required 6", nfr);
    end
    checks++;
    if (xp[2] !== 11'h7FE || yp[2] !== 11'd501) begin
      failures++;
      $display("FAIL swap_final: got (%0d,%0d) required (2046,501)", xp[2], yp[2]);
    end
    checks++;
    if (res[2] !== 2'b01 || npulse !== 1) begin
      failures++;
      $display("FAIL swap_result: got res=%b pulses=%0d required res=01 pulses=1",
               res[2], npulse);
    end
  endtask

  task automatic test_timeout();
    pw[3] = 4'd0;
    tn[3] = 1'b0;
    fly(3, 11'd100);
    checks++;
    if (nfr !== 5) begin
      failures++;
      $display("FAIL timeout_frames: got %0d required 5", nfr);
    end
    checks++;
    if (xp[3] !== 11'd110 || yp[3] !== 11'd590) begin
      failures++;
      $display("FAIL timeout_final: got (%0d,%0d) required (110,590)", xp[3], yp[3]);
    end
    checks++;
    if (res[3] !== 2'b01 || npulse !== 1) begin
      failures++;
      $display("FAIL timeout_result: got res=%b pulses=%0d required res=01 pulses=1",
               res[3], npulse);
    end
  endtask

  task automatic test_rst_mid();
    logic reached;
    logic bad;
    reached = 1'b0;
    bad     = 1'b0;
    pw[0]   = 4'd0;
    tn[0]   = 1'b0;
    thr[0]  = 1'b1;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(posedge clk); #1;
      if (et[0]) bad = 1'b1;
      if (vis[0] && xp[0] == 11'd106) reached = 1'b1;
    end
    checks++;
    if (reached !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_reach_frame3: got %0b required 1", reached);
    end
    rst    = 1'b1;
    thr[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({et[0], vis[0], res[0], xp[0], yp[0]} !== 26'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: et=%0b vis=%0b res=%b x=%0d y=%0d required all 0",
               et[0], vis[0], res[0], xp[0], yp[0]);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (et[0] || vis[0]) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_no_pulse: got %0b required 0", bad);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ground();
    test_done_hold();
    test_drop_midflight();
    test_hit();
    test_swap();
    test_timeout();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
